enc_tx_serializer: RTL and testbench
====================================

ENC_TX_SERIALIZER -- requirements
Module: enc_tx_serializer

Interface
REQ-001 Parameter: APPEND_CRLF, default 1, when 1 append 0x0D then 0x0A after the 10 payload bytes.
REQ-002 Parameter: ACK_WAIT, default 4, max cycles to wait for i_tx_busy rising after a strobe.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_data  input  80  10 symbol codes, byte 0 = i_data[79:72] sent first, byte 9 = i_data[7:0] sent last.
REQ-006 i_start  input  1  request to send i_data; sampled only in IDLE.
REQ-007 i_tx_busy  input  1  busy flag from the UART transmitter.
REQ-008 o_tx_data  output  8  ASCII byte presented to the UART transmitter.
REQ-009 o_tx_stb  output  1  one-cycle transmit strobe, qualifies o_tx_data.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse when the last byte has completed.

Function
REQ-012 FSM states SHALL be IDLE, STROBE, WAIT_ACK, WAIT_IDLE, DONE.
REQ-013 IDLE with i_start=1 SHALL latch i_data into an internal 80-bit shift register, clear byte counter to 0, and go to STROBE.
REQ-014 i_start SHALL be ignored in every state other than IDLE; latched payload is not modified mid-message.
REQ-015 STROBE SHALL wait while i_tx_busy=1; when i_tx_busy=0 it SHALL assert o_tx_stb for exactly one cycle with o_tx_data = converted current byte, then go to WAIT_ACK.
REQ-016 WAIT_ACK SHALL go to WAIT_IDLE on first cycle i_tx_busy=1, or after ACK_WAIT cycles without it (byte treated as accepted).
REQ-017 WAIT_IDLE SHALL hold until i_tx_busy=0, then advance counter; if more bytes remain go to STROBE, else go to DONE.
REQ-018 Byte count SHALL be 10, or 12 when APPEND_CRLF=1; counter indices 10 and 11 select 0x0D and 0x0A, bypassing conversion.
REQ-019 Conversion code->ASCII: 0x00-0x09 -> 0x30+code; 0x0A-0x23 -> 0x41+(code-0x0A); 0x24-0x3D -> 0x61+(code-0x24); 0x3E -> 0x3F ('?'); 0x3F -> 0x21 ('!'); any code >= 0x40 -> 0x20 (space).
REQ-020 o_tx_data SHALL be registered and held stable from the strobe cycle until the next strobe; value outside strobes is don't-care but SHALL be 0x00 after reset.
REQ-021 DONE SHALL assert o_done for one cycle and return to IDLE; o_busy low from the following cycle.
REQ-022 i_start high in the DONE cycle SHALL be ignored; a new message starts no earlier than the first IDLE cycle.
REQ-023 Minimum latency: i_start at cycle N with i_tx_busy=0 -> first o_tx_stb at cycle N+2.
REQ-024 i_tx_busy stuck high SHALL stall the block indefinitely in STROBE or WAIT_IDLE with no strobe issued.

Reset
REQ-025 rst=1 SHALL force state IDLE, counter 0, o_tx_stb=0, o_done=0, o_busy=0, o_tx_data=0x00 on the next clock edge.
REQ-026 rst asserted mid-message SHALL abort without further strobes; remaining bytes are discarded.
REQ-027 rst has priority over i_start in the same cycle.

Verification
REQ-028 Idle UART model (busy 3 cycles after each strobe), i_data codes {0x11,0x0E,0x15,0x15,0x18,0x3E,0x3F,0x00,0x09,0x40}, APPEND_CRLF=1 -> 12 strobes with bytes "HELLO?!09 " then 0x0D,0x0A, then one o_done pulse.
REQ-029 Full code sweep 0x00-0x3F plus 0x40,0x7F,0xFF across 7 messages -> every byte matches REQ-019 table; 0x40/0x7F/0xFF -> 0x20.
REQ-030 i_tx_busy held high 50 cycles after start -> zero strobes, o_busy=1; release busy -> first byte strobed within 1 cycle of busy falling.
REQ-031 UART model never raises busy -> each byte advances after ACK_WAIT=4 cycles; 12 strobes, o_done asserted.
REQ-032 rst pulsed after 4th strobe -> no further strobes, o_busy=0 next cycle; new i_start sends all bytes from byte 0.
REQ-033 i_start pulsed repeatedly during a message with different i_data -> output bytes equal the originally latched payload only; APPEND_CRLF=0 run yields exactly 10 strobes.

Source files
------------

// File: rtl/enc_tx_serializer.sv
// enc_tx_serializer: turns a 10-symbol message into ASCII bytes for a UART transmitter.
// Latency: i_start -> first o_tx_stb in 2 cycles when the UART is idle.
// Backpressure: a byte is not strobed while i_tx_busy is high, so a busy UART stalls the block.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   i_data[79:0]      10 symbol codes, byte 0 in [79:72] is sent first
//   i_start           send request, only looked at in IDLE
//   i_tx_busy         busy flag from the UART transmitter
//   o_tx_data[7:0]    ASCII byte, held from its strobe until the next strobe
//   o_tx_stb          one-cycle strobe qualifying o_tx_data
//   o_busy            high whenever the FSM is not in IDLE
//   o_done            one-cycle pulse after the last byte has completed
module enc_tx_serializer #(
  parameter int APPEND_CRLF = 1,
  parameter int ACK_WAIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] i_data,
  input  logic        i_start,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  output logic        o_busy,
  output logic        o_done
);

  localparam int         NBYTES = (APPEND_CRLF != 0) ? 12 : 10;
  localparam int         AW     = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [3:0] LAST   = 4'(NBYTES - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  state_t        r_state;
  logic [79:0]   r_shift;
  logic [3:0]    r_idx;
  logic [AW-1:0] r_ack_cnt;
  logic [7:0]    r_tx_data;
  logic          r_tx_stb;
  logic          r_busy;
  logic          r_done;

  logic [7:0]    w_code;
  logic [7:0]    w_ascii;
  logic [7:0]    w_byte;

  // The current symbol always sits in the top byte; the register shifts left
  // by one byte each time a byte completes.
  assign w_code = r_shift[79:72];

  always_comb begin
    if (w_code <= 8'h09)      w_ascii = 8'h30 + w_code;
    else if (w_code <= 8'h23) w_ascii = 8'h41 + (w_code - 8'h0A);
    else if (w_code <= 8'h3D) w_ascii = 8'h61 + (w_code - 8'h24);
    else if (w_code == 8'h3E) w_ascii = 8'h3F;
    else if (w_code == 8'h3F) w_ascii = 8'h21;
    else                      w_ascii = 8'h20;
  end

  // Indices 10 and 11 are the CR/LF trailer and bypass the symbol table.
  always_comb begin
    if (r_idx == 4'd10)      w_byte = 8'h0D;
    else if (r_idx == 4'd11) w_byte = 8'h0A;
    else                     w_byte = w_ascii;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_ack_cnt <= '0;
      r_tx_data <= 8'h00;
      r_tx_stb  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx_stb <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shift <= i_data;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          if (!i_tx_busy) begin
            r_tx_stb  <= 1'b1;
            r_tx_data <= w_byte;
            r_ack_cnt <= '0;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A UART that never raises busy is treated as having accepted the
          // byte once the acknowledge window runs out.
          if (i_tx_busy || (r_ack_cnt == ACK_LAST)) begin
            r_state <= WAIT_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + AW'(1);
          end
        end
        WAIT_IDLE: begin
          if (!i_tx_busy) begin
            if (r_idx == LAST) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_shift <= {r_shift[71:0], 8'h00};
              r_state <= STROBE;
            end
          end
        end
        DONE: begin
          // o_done is high during this state; busy drops as IDLE is entered.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_stb  = r_tx_stb;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_enc_tx_serializer.sv
module tb_enc_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] data = '0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_busy0 = 1'b0;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_stb, tx_stb0, busy, busy0, done, done0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done0_cnt = 0;
  int mode = 0;       // UART model: 0 = busy 3 cycles per strobe, 1 = never busy, 2 = stuck busy
  int ucnt = 0;
  int st_cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int sc[$];

  enc_tx_serializer #(.APPEND_CRLF(1), .ACK_WAIT(4)) dut (
    .clk(clk), .rst(rst), .i_data(data), .i_start(start), .i_tx_busy(tx_busy),
    .o_tx_data(tx_data), .o_tx_stb(tx_stb), .o_busy(busy), .o_done(done)
  );

  enc_tx_serializer #(.APPEND_CRLF(0), .ACK_WAIT(4)) dut0 (
    .clk(clk), .rst(rst), .i_data(data), .i_start(start0), .i_tx_busy(tx_busy0),
    .o_tx_data(tx_data0), .o_tx_stb(tx_stb0), .o_busy(busy0), .o_done(done0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus UART model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (tx_stb) begin
      q1.push_back(tx_data);
      sc.push_back(cyc);
    end
    if (done) done_cnt = done_cnt + 1;
    if (tx_stb0) q0.push_back(tx_data0);
    if (done0) done0_cnt = done0_cnt + 1;
    if (mode == 2) begin
      tx_busy = 1'b1;
      ucnt = 0;
    end else if (mode == 1) begin
      tx_busy = 1'b0;
      ucnt = 0;
    end else begin
      if (tx_stb) ucnt = 3;
      tx_busy = (ucnt > 0);
      if (ucnt > 0) ucnt = ucnt - 1;
    end
  end

  function automatic logic [7:0] exp_char(input logic [7:0] c);
    string tbl;
    tbl = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz?!";
    if (c < 8'd64) return tbl[int'(c)];
    return 8'h20;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [79:0] d, input int i);
    if (i == 10) return 8'h0D;
    if (i == 11) return 8'h0A;
    return exp_char(d[79-8*i -: 8]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q1.delete();
    q0.delete();
    sc.delete();
    done_cnt = 0;
    done0_cnt = 0;
  endtask

  task automatic send(input logic [79:0] d);
    data = d;
    start = 1'b1;
    st_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      step();
      n++;
    end
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL %s: timeout waiting for o_done, got 0 pulses, want 1", name);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total += 4;
    if (tx_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", tx_stb); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_hello();
    string exp_s;
    exp_s = "HELLO?!09 \r\n";
    mode = 0;
    clear_mon();
    send(80'h110E1515183E3F000940);
    wait_done("hello");
    total++;
    if (q1.size() !== 12) begin bad++; $display("FAIL hello_count: got %0d want 12", q1.size()); end
    for (int i = 0; i < 12 && i < q1.size(); i++) begin
      total++;
      if (q1[i] !== exp_s[i]) begin
        bad++; $display("FAIL hello_byte%0d: got %h want %h", i, q1[i], exp_s[i]);
      end
    end
    total += 2;
    if (done_cnt !== 1) begin bad++; $display("FAIL hello_done: got %0d want 1", done_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL hello_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_sweep();
    logic [7:0] codes[70];
    logic [79:0] d;
    for (int i = 0; i < 64; i++) codes[i] = 8'(i);
    codes[64] = 8'h40; codes[65] = 8'h7F; codes[66] = 8'hFF;
    codes[67] = 8'h80; codes[68] = 8'h3E; codes[69] = 8'h0A;
    mode = 0;
    for (int m = 0; m < 7; m++) begin
      for (int j = 0; j < 10; j++) d[79-8*j -: 8] = codes[m*10+j];
      clear_mon();
      send(d);
      wait_done("sweep");
      total++;
      if (q1.size() !== 12) begin bad++; $display("FAIL sweep%0d_count: got %0d want 12", m, q1.size()); end
      for (int i = 0; i < 12 && i < q1.size(); i++) begin
        total++;
        if (q1[i] !== exp_byte(d, i)) begin
          bad++; $display("FAIL sweep%0d_byte%0d: got %h want %h", m, i, q1[i], exp_byte(d, i));
        end
      end
    end
  endtask

  task automatic test_stall();
    int rel;
    mode = 2;
    step();
    clear_mon();
    send(80'h0A0B0C0D0E0F10111213);
    repeat (50) step();
    total += 2;
    if (q1.size() !== 0) begin bad++; $display("FAIL stall_nostb: got %0d strobes want 0", q1.size()); end
    if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy); end
    mode = 0;
    rel = cyc;
    wait_done("stall");
    total += 2;
    if (q1.size() !== 12) begin bad++; $display("FAIL stall_count: got %0d want 12", q1.size()); end
    if (sc.size() == 0 || sc[0] !== rel + 1) begin
      bad++; $display("FAIL stall_release: first strobe cycle %0d want %0d", (sc.size() > 0) ? sc[0] : -1, rel + 1);
    end
  endtask

  task automatic test_ack_timeout();
    mode = 1;
    step();
    clear_mon();
    send(80'h000102030405060708FF);
    wait_done("ackwait");
    total += 3;
    if (q1.size() !== 12) begin bad++; $display("FAIL ackwait_count: got %0d want 12", q1.size()); end
    if (done_cnt !== 1) begin bad++; $display("FAIL ackwait_done: got %0d want 1", done_cnt); end
    if (sc.size() == 0 || sc[0] !== st_cyc + 2) begin
      bad++; $display("FAIL latency: first strobe cycle %0d want %0d", (sc.size() > 0) ? sc[0] : -1, st_cyc + 2);
    end
    // Strobe, 4 acknowledge-window cycles, one WAIT_IDLE, one STROBE cycle.
    for (int i = 1; i < sc.size(); i++) begin
      total++;
      if (sc[i] - sc[i-1] !== 6) begin
        bad++; $display("FAIL ackwait_gap%0d: got %0d want 6", i, sc[i] - sc[i-1]);
      end
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [79:0] d;
    int n;
    d = 80'h1D1E1F20212223242526;
    mode = 0;
    clear_mon();
    send(d);
    n = 0;
    while (q1.size() < 4 && n < 500) begin step(); n++; end
    rst = 1'b1;
    step();
    total += 3;
    if (q1.size() !== 4) begin bad++; $display("FAIL rstmid_reach: got %0d strobes want 4", q1.size()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", tx_data); end
    rst = 1'b0;
    repeat (30) step();
    total++;
    if (q1.size() !== 4) begin bad++; $display("FAIL rstmid_nomore: got %0d strobes want 4", q1.size()); end
    clear_mon();
    send(d);
    wait_done("rstmid");
    total++;
    if (q1.size() !== 12) begin bad++; $display("FAIL rstmid_count: got %0d want 12", q1.size()); end
    for (int i = 0; i < 12 && i < q1.size(); i++) begin
      total++;
      if (q1[i] !== exp_byte(d, i)) begin
        bad++; $display("FAIL rstmid_byte%0d: got %h want %h", i, q1[i], exp_byte(d, i));
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [79:0] a;
    int n;
    a = 80'h2425262728292A2B2C2D;
    clear_mon();
    data = a;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      repeat (6) step();
      data = {8'(k), 72'h3F3E3D3C3B3A393837};
      start0 = 1'b1;
      step();
      start0 = 1'b0;
    end
    n = 0;
    while (done0_cnt == 0 && n < 500) begin step(); n++; end
    repeat (20) step();
    total += 2;
    if (done0_cnt !== 1) begin bad++; $display("FAIL nocrlf_done: got %0d want 1", done0_cnt); end
    if (q0.size() !== 10) begin bad++; $display("FAIL nocrlf_count: got %0d want 10", q0.size()); end
    for (int i = 0; i < 10 && i < q0.size(); i++) begin
      total++;
      if (q0[i] !== exp_byte(a, i)) begin
        bad++; $display("FAIL restart_byte%0d: got %h want %h", i, q0[i], exp_byte(a, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_sweep();
    test_stall();
    test_ack_timeout();
    test_reset_mid();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
